// File: rtl/mem_agent_types.sv
// Shared AXI read-side types and constants for the mem_agent traffic generator
// and its loopback read responder.
package mem_agent_types;

   localparam int          AXI_ID_WIDTH           = 4;
   localparam int          AXI_DATA_WIDTH         = 128;
   localparam int          DEBUG_COUNTER_BITS     = 32;
   localparam int          AXI_RD_OUTSTANDING_MAX = 16;
   localparam logic [31:0] AXI_RD_ADDR_BASE       = 32'h4000_0000;
   localparam logic [31:0] AXI_RD_ADDR_HIGH       = 32'h8000_0000;
   localparam logic [2:0]  AXI_MASTER_SIZE        = 3'd4;
   localparam logic [1:0]  AXI_BURST_INCR         = 2'b01;
   localparam logic [1:0]  AXI_RESP_OKAY          = 2'b00;
   localparam logic [1:0]  AXI_RESP_SLVERR        = 2'b10;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0] id;
      logic [31:0]             addr;
      logic [7:0]              len;
      logic [2:0]              size;
      logic [1:0]              burst;
   } ar_req_t;

   typedef enum logic [1:0] {IDLE, WAIT, DATA} rd_rsp_state_t;

   typedef struct packed {
      logic en;
   } fifo_wr_if_t;

   typedef struct packed {
      logic en;
   } fifo_rd_if_t;

endpackage

// File: rtl/mem_agent_sync_fifo.sv
// Show-ahead synchronous FIFO: rd_data always presents the oldest entry,
// rd.en retires it. Writes when full and reads when empty are ignored.
module mem_agent_sync_fifo
   import mem_agent_types::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  fifo_wr_if_t       wr,
   input  logic [WIDTH-1:0]  wr_data,
   input  fifo_rd_if_t       rd,
   output logic [WIDTH-1:0]  rd_data,
   output logic              empty,
   output logic [CW-1:0]     count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_wr, do_rd;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign empty   = (count == '0);
   assign do_wr   = wr.en && (count != CW'(DEPTH));
   assign do_rd   = rd.en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
         if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(do_wr) - CW'(do_rd);
      end
   end

endmodule

// File: rtl/mem_agent_rd_responder.sv
// AXI4 read responder standing in for DDR: queues AR requests and answers each
// with an address-pattern R burst (or an all-SLVERR burst for illegal requests).
module mem_agent_rd_responder
   import mem_agent_types::*;
#(
   parameter int          RD_LATENCY      = 4,
   parameter int          OUTSTANDING_MAX = AXI_RD_OUTSTANDING_MAX,
   parameter logic [31:0] ADDR_BASE       = AXI_RD_ADDR_BASE,
   parameter logic [31:0] ADDR_HIGH       = AXI_RD_ADDR_HIGH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          s_arvalid,
   output logic                          s_arready,
   input  logic [31:0]                   s_araddr,
   input  logic [7:0]                    s_arlen,
   input  logic [2:0]                    s_arsize,
   input  logic [1:0]                    s_arburst,
   input  logic [AXI_ID_WIDTH-1:0]       s_arid,
   output logic                          s_rvalid,
   input  logic                          s_rready,
   output logic [AXI_DATA_WIDTH-1:0]     s_rdata,
   output logic [1:0]                    s_rresp,
   output logic                          s_rlast,
   output logic [AXI_ID_WIDTH-1:0]       s_rid,
   output logic [DEBUG_COUNTER_BITS-1:0] dbg_ar_cnt,
   output logic [DEBUG_COUNTER_BITS-1:0] dbg_beat_cnt,
   output logic [DEBUG_COUNTER_BITS-1:0] dbg_err_cnt
);

   localparam int CW = $clog2(OUTSTANDING_MAX + 1);

   ar_req_t                 ar_in, head;
   fifo_wr_if_t             ar_wr;
   fifo_rd_if_t             ar_rd;
   logic                    empty;
   logic [CW-1:0]           count;
   logic [CW:0]             next_cnt;
   logic                    push, pop, r_hs;
   rd_rsp_state_t           state, nxt;
   logic [7:0]              lat_cnt, beat, cur_len;
   logic [31:0]             cur_addr;
   logic [AXI_ID_WIDTH-1:0] cur_id;
   logic                    cur_err;

   // End address is formed in 33 bits so a burst running past 2^32 cannot wrap into range.
   function automatic logic burst_err(input ar_req_t r);
      logic [32:0] end_addr;
      end_addr = {1'b0, r.addr} + (({25'd0, r.len} + 33'd1) << 4);
      return (r.burst != AXI_BURST_INCR) || (r.size != AXI_MASTER_SIZE) ||
             (r.addr < ADDR_BASE) || (end_addr > {1'b0, ADDR_HIGH});
   endfunction

   function automatic logic [AXI_DATA_WIDTH-1:0] beat_pattern(input logic [31:0] a);
      logic [AXI_DATA_WIDTH-1:0] d;
      for (int i = 0; i < AXI_DATA_WIDTH / 32; i++) d[32*i +: 32] = a + 32'(4 * i);
      return d;
   endfunction

   assign ar_in    = '{id: s_arid, addr: s_araddr, len: s_arlen, size: s_arsize, burst: s_arburst};
   assign push     = s_arvalid && s_arready;
   assign r_hs     = s_rvalid && s_rready;
   assign ar_wr.en = push;
   assign ar_rd.en = pop;
   assign next_cnt = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);

   mem_agent_sync_fifo #(
      .WIDTH ($bits(ar_req_t)),
      .DEPTH (OUTSTANDING_MAX)
   ) u_ar_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr      (ar_wr),
      .wr_data (ar_in),
      .rd      (ar_rd),
      .rd_data (head),
      .empty   (empty),
      .count   (count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         lat_cnt      <= '0;
         beat         <= '0;
         s_arready    <= 1'b0;
         dbg_ar_cnt   <= '0;
         dbg_beat_cnt <= '0;
         dbg_err_cnt  <= '0;
      end else begin
         state     <= nxt;
         s_arready <= (next_cnt < (CW+1)'(OUTSTANDING_MAX));
         if (state == IDLE) begin
            lat_cnt <= 8'(RD_LATENCY);
            beat    <= '0;
         end else if (state == WAIT) begin
            lat_cnt <= lat_cnt - 8'd1;
         end else if (r_hs) begin
            beat <= beat + 8'd1;
         end
         dbg_ar_cnt   <= dbg_ar_cnt + DEBUG_COUNTER_BITS'(push);
         dbg_beat_cnt <= dbg_beat_cnt + DEBUG_COUNTER_BITS'(r_hs);
         dbg_err_cnt  <= dbg_err_cnt + DEBUG_COUNTER_BITS'(pop && cur_err);
      end
   end

   // Burst working copy: head stays queued until its last beat is accepted.
   always_ff @(posedge clk) begin
      if (state == IDLE && !empty) begin
         cur_addr <= {head.addr[31:4], 4'b0};
         cur_len  <= head.len;
         cur_id   <= head.id;
         cur_err  <= burst_err(head);
      end else if (r_hs) begin
         cur_addr <= cur_addr + 32'd16;
      end
   end

   always_comb begin
      nxt      = state;
      s_rvalid = 1'b0;
      pop      = 1'b0;
      case (state)
         IDLE: if (!empty) nxt = (RD_LATENCY == 0) ? DATA : WAIT;
         WAIT: if (lat_cnt <= 8'd1) nxt = DATA;
         DATA: begin
            s_rvalid = 1'b1;
            if (s_rready && (beat == cur_len)) begin
               pop = 1'b1;
               nxt = IDLE;
            end
         end
         default: nxt = IDLE;
      endcase
   end

   assign s_rlast = s_rvalid && (beat == cur_len);
   assign s_rresp = (s_rvalid && cur_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
   assign s_rdata = (s_rvalid && !cur_err) ? beat_pattern(cur_addr) : '0;
   assign s_rid   = s_rvalid ? cur_id : '0;

endmodule

// File: doc/mem_agent_rd_responder.md
Name: mem_agent_rd_responder

Overview:
AXI4 read-channel responder (slave) that stands in for DDR in loopback tests of the mem_agent AXI master traffic generator. It accepts AR requests into an outstanding queue and returns R bursts whose data is a self-describing address pattern, so the master can check every beat. It is instantiated in the mem_agent simulation and bring-up top, attached directly to the master's read channels.

Parameters:
RD_LATENCY, 4, idle cycles between a burst reaching queue head and its first rvalid (0..255)
OUTSTANDING_MAX, mem_agent_types::AXI_RD_OUTSTANDING_MAX (16), max accepted-but-uncompleted bursts
ADDR_BASE, mem_agent_types::AXI_RD_ADDR_BASE, lowest legal byte address
ADDR_HIGH, mem_agent_types::AXI_RD_ADDR_HIGH, exclusive upper bound of legal addresses

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
s_arvalid  in  1  AR valid
s_arready  out  1  AR ready
s_araddr  in  32  AR byte address
s_arlen  in  8  beats minus 1
s_arsize  in  3  beat size
s_arburst  in  2  burst type
s_arid  in  AXI_ID_WIDTH  transaction ID
s_rvalid  out  1  R valid
s_rready  in  1  R ready
s_rdata  out  128  R data
s_rresp  out  2  R response
s_rlast  out  1  last beat of burst
s_rid  out  AXI_ID_WIDTH  echoed arid
dbg_ar_cnt  out  DEBUG_COUNTER_BITS  accepted AR count
dbg_beat_cnt  out  DEBUG_COUNTER_BITS  completed R beats
dbg_err_cnt  out  DEBUG_COUNTER_BITS  bursts answered SLVERR

Behaviour:
- Reset (async assert, sync release): all outputs 0, queue empty, FSM in IDLE, counters 0. Reset mid-burst drops rvalid immediately and discards all queued bursts.
- AR queue: show-ahead FIFO of ar_req_t, depth OUTSTANDING_MAX. Push on arvalid&&arready. The head is NOT popped when service starts; it is popped on the rlast handshake, so outstanding = FIFO count.
- s_arready is registered: next value = (next_count < OUTSTANDING_MAX). It is 0 in reset and 1 the first cycle after release. There is no same-cycle bypass: when full, a simultaneous pop does not raise arready until the next cycle.
- FSM IDLE -> WAIT -> DATA -> IDLE.
  - IDLE: if the FIFO is non-empty, latch head into working regs; lat_cnt = RD_LATENCY; go to WAIT, or to DATA when RD_LATENCY = 0.
  - WAIT: decrement lat_cnt; go to DATA when it reaches 1.
  - Net timing: head seen in IDLE at cycle t gives rvalid first high at t+1+RD_LATENCY.
  - DATA: rvalid=1. On each rvalid&&rready: beat++, and the beat address advances by 16.
  - rlast = (beat == arlen). On the rlast handshake: pop the FIFO and go to IDLE. This gives a one-cycle bubble between bursts.
- Stability: rdata/rresp/rlast/rid are held stable while rvalid && !rready.
- Error check (per burst, latched at service start): resp = SLVERR (2'b10) if any of the following hold, else OKAY (2'b00):
  - arburst != INCR (2'b01)
  - arsize != AXI_MASTER_SIZE
  - araddr < ADDR_BASE
  - araddr + (arlen+1)*16 > ADDR_HIGH, computed in 33 bits with no wrap
- Every beat of a SLVERR burst carries that resp, with rdata = 0. arlen+1 beats are always returned.
- Data pattern (OKAY): beat_addr = {araddr[31:4],4'b0} + 16*beat. The 32-bit lane i of rdata (bits 32i+31:32i) = beat_addr + 4i. An unaligned araddr is aligned down. No 4 KB boundary check is performed.
- Counters: 32-bit, wrap modulo 2^32.
  - dbg_ar_cnt: +1 per AR handshake.
  - dbg_beat_cnt: +1 per R handshake.
  - dbg_err_cnt: +1 per SLVERR rlast handshake.
- Simultaneous AR push and rlast pop: count unchanged, arready stays as registered.

Decomposition:
- mem_agent_types additions:
  - AXI_ID_WIDTH = 4
  - AXI_BURST_INCR = 2'b01
  - AXI_RESP_OKAY = 2'b00, AXI_RESP_SLVERR = 2'b10
  - ar_req_t packed struct (id, addr, len, size, burst)
  - rd_rsp_state_t enum (IDLE, WAIT, DATA)
- Sub-module mem_agent_sync_fifo: parameterised width/depth show-ahead FIFO using the existing fifo_wr_if_t/fifo_rd_if_t, with a count output. Used for the AR queue.

Test Plan:
- RD_LATENCY=4, AR addr 0x4000_0000 len 3 id 5, rready=1:
  - 4 beats; first rvalid 5 cycles after AR handshake.
  - Beat0 rdata = 0x4000000C_40000008_40000004_40000000, beat3 lanes base 0x4000_0030.
  - rresp=OKAY, rid=5, rlast only on beat3.
- AR addr 0x8000_0000 len 0, then 0x7FFF_FFF0 len 1, then burst=FIXED at 0x4000_0000:
  - Every beat SLVERR with rdata=0; beat counts 1/2/1; dbg_err_cnt=3.
- rready toggled 1-0-0-1 during an 8-beat burst -> outputs stable during stalls, no beat lost or duplicated, dbg_beat_cnt=8.
- rready=0, issue 20 back-to-back ARs:
  - Exactly 16 accepted, arready low from the cycle after the 16th.
  - Releasing rready drains IDs in order; arready returns the cycle after the first rlast.
- Assert rst during beat 2 of a 4-beat burst -> rvalid and arready 0 immediately, counters 0. A new AR after release completes normally.
- RD_LATENCY=0, two queued len-0 bursts -> rvalid at t+1, then exactly one idle cycle between the two beats.
